// File: rtl/inst_prefetch_buf_pkg.sv
// Shared definitions for the instruction prefetch buffer: FSM encoding and word width.
package inst_prefetch_buf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam int INST_W = 32;

endpackage

// File: rtl/inst_prefetch_buf_fifo.sv
// inst_fifo: DEPTH x W storage for fetched {pc, inst} pairs; clear has priority over push/pop.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !clear;
    do_pop   = pop && !empty && !clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch buffer: issues ROM reads, queues {pc, inst}, flushes on redirect.
// Optional counters stat_fetch/stat_drop/stat_stall when INST_PREFETCH_STATS_EN is defined.
//
//   state   | meaning
//   S_IDLE  | first cycle after reset release, no fetch
//   S_FETCH | issue reads while credit allows and halt is low
//   S_HALT  | fetch stopped, FIFO keeps draining
module inst_prefetch_buf
  import inst_prefetch_buf_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [AW-1:0]     rom_addr,
  input  logic [INST_W-1:0] rom_data,
  input  logic              redirect,
  input  logic [AW-1:0]     redirect_pc,
  input  logic              halt,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [AW-1:0]     id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef INST_PREFETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetch,
  output logic [15:0]       stat_drop,
  output logic [31:0]       stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + INST_W;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ret_pc_q, ret_pc_d;
  logic          inflight_q, inflight_d;
  logic          tag_q, tag_d;
  logic          epoch_q, epoch_d;

  logic          issue, credit_ok, ret_ok, drop_ret;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_head;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // count + inflight never exceeds DEPTH, so a returning word always has a slot.
  assign credit_ok = ((fifo_count + CW'(inflight_q)) < CW'(DEPTH)) && !fifo_full;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ret_pc_d   = ret_pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    epoch_d    = epoch_q;
    issue      = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        issue = credit_ok && !halt && !redirect;
        if (halt) state_d = S_HALT;
      end
      S_HALT:  if (!halt) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      pc_d       = pc_q + AW'(4);
      ret_pc_d   = pc_q;
      inflight_d = 1'b1;
      tag_d      = epoch_q;
    end
    if (redirect) begin
      pc_d    = {redirect_pc[AW-1:2], 2'b00};
      epoch_d = ~epoch_q;
    end
  end

  always_comb begin
    ret_ok    = inflight_q && (tag_q == epoch_q) && !redirect;
    drop_ret  = inflight_q && !ret_ok;
    fifo_push = ret_ok;
    fifo_pop  = id_valid && id_ready && !redirect;
    rom_ce    = issue;
    rom_addr  = issue ? pc_q : '0;
    id_valid  = !fifo_empty;
    id_pc     = id_valid ? fifo_head[EW-1:INST_W] : '0;
    id_inst   = id_valid ? fifo_head[INST_W-1:0]  : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ret_pc_q   <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      epoch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_pc_q   <= ret_pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      epoch_q    <= epoch_d;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data ({ret_pc_q, rom_data}),
    .pop       (fifo_pop),
    .clear     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

`ifdef INST_PREFETCH_STATS_EN
  logic [31:0] stat_fetch_q, stat_fetch_d;
  logic [15:0] stat_drop_q, stat_drop_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [15:0] drop_inc;

  always_comb begin
    stat_fetch_d = stat_fetch_q;
    stat_stall_d = stat_stall_q;
    drop_inc     = 16'(drop_ret) + (redirect ? 16'(fifo_count) : 16'd0);
    if (issue && stat_fetch_q != 32'hFFFF_FFFF) stat_fetch_d = stat_fetch_q + 32'd1;
    if (id_ready && !id_valid && stat_stall_q != 32'hFFFF_FFFF) stat_stall_d = stat_stall_q + 32'd1;
    if (stat_drop_q > (16'hFFFF - drop_inc)) stat_drop_d = 16'hFFFF;
    else                                      stat_drop_d = stat_drop_q + drop_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetch_q <= '0;
      stat_drop_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_fetch_q <= stat_fetch_d;
      stat_drop_q  <= stat_drop_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_fetch = stat_fetch_q;
  assign stat_drop  = stat_drop_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
